// File: rtl/display_pkg.sv
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and default geometry for the display fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int H_WORDS_DEF = 50;
   localparam int V_LINES_DEF = 600;
   localparam int FB_WORDS    = H_WORDS_DEF * V_LINES_DEF;

   typedef logic [ADDR_W_DEF-1:0] vram_addr_t;

   typedef enum logic [1:0] {
      PREFILL = 2'd0,
      ACTIVE  = 2'd1,
      DONE    = 2'd2
   } fetch_state_t;

endpackage : display_pkg

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous prefetch FIFO with flush, count and head output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_fifo #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 16,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              empty_o,
   output logic              full_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointers are PTR_W wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !rst_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule : pixel_fifo

`default_nettype wire

// File: rtl/display_fetch_arbiter.sv
// ============================================================================
//  Module      : display_fetch_arbiter
//  Description : Shares one VRAM port between framebuffer prefetch and the CPU.
//                Optional DISP_UNDERFLOW_CNT_EN adds a saturating underflow_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_fetch_arbiter
   import display_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int H_WORDS    = H_WORDS_DEF,
   parameter int V_LINES    = V_LINES_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK_VGA,
   input  logic              reset,
   input  logic              newData,
   input  logic              end_of_frame,
   output logic [15:0]       pixel_row,
   output logic              underflow,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [15:0]       vram_wdata,
   input  logic [15:0]       vram_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [15:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [15:0]       cpu_rdata
`ifdef DISP_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]       underflow_cnt
`endif
);

   localparam int                CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] FB_END = ADDR_W'(H_WORDS * V_LINES);

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic [ADDR_W-1:0] fetch_ptr_q;
   logic [ADDR_W-1:0] fetch_ptr_d;
   logic              inflight_q;
   logic              rvalid_q;
   logic              underflow_q;

   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occupancy;
   logic [15:0]       fifo_head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_push;
   logic              ptr_end;
   logic              disp_need;
   logic              disp_slot;
   logic              underflow_evt;

   // Occupancy counts the in-flight word so the FIFO can never overfill.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
   assign ptr_end   = (fetch_ptr_q == FB_END);
   assign disp_need = (occupancy < (CNT_W+1)'(FIFO_DEPTH)) && (state_q != DONE) && !ptr_end;
   assign disp_slot = disp_need && !end_of_frame && !reset;
   assign cpu_gnt   = cpu_req && !disp_slot && !reset;

   // A word landing during end_of_frame belongs to the old frame and is dropped.
   assign fifo_push     = inflight_q && !end_of_frame;
   assign underflow_evt = newData && fifo_empty;

   pixel_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (16)
   ) u_pixel_fifo (
      .clk_i       (CLK_VGA),
      .rst_i       (reset),
      .flush_i     (end_of_frame),
      .push_i      (fifo_push),
      .push_data_i (vram_rdata),
      .pop_i       (newData),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   always_ff @(posedge CLK_VGA) begin
      if (reset) begin
         state_q <= PREFILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (end_of_frame) begin
         state_d = PREFILL;
      end else begin
         case (state_q)
            PREFILL: if (fifo_full) state_d = ACTIVE;
            ACTIVE:  if (ptr_end)   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = PREFILL;
         endcase
      end
   end

   always_comb begin
      vram_addr  = '0;
      vram_we    = 1'b0;
      vram_wdata = '0;
      if (disp_slot) begin
         vram_addr = fetch_ptr_q;
      end else if (cpu_gnt) begin
         vram_addr = cpu_addr;
         vram_we   = cpu_we;
         if (cpu_we) vram_wdata = cpu_wdata;
      end
   end

   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      if (end_of_frame) begin
         fetch_ptr_d = '0;
      end else if (disp_slot) begin
         fetch_ptr_d = fetch_ptr_q + 1'b1;
      end
   end

   // The CPU read return is not cancelled by end_of_frame.
   always_ff @(posedge CLK_VGA) begin
      if (reset) begin
         fetch_ptr_q <= '0;
         inflight_q  <= 1'b0;
         rvalid_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         fetch_ptr_q <= fetch_ptr_d;
         inflight_q  <= disp_slot;
         rvalid_q    <= cpu_gnt && !cpu_we;
         if (underflow_evt) underflow_q <= 1'b1;
      end
   end

   assign pixel_row  = fifo_head;
   assign underflow  = underflow_q;
   assign cpu_rvalid = rvalid_q;
   assign cpu_rdata  = rvalid_q ? vram_rdata : 16'h0000;

`ifdef DISP_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt_q;

   always_ff @(posedge CLK_VGA) begin
      if (reset) begin
         underflow_cnt_q <= '0;
      end else if (underflow_evt && (underflow_cnt_q != 16'hFFFF)) begin
         underflow_cnt_q <= underflow_cnt_q + 16'd1;
      end
   end

   assign underflow_cnt = underflow_cnt_q;
`endif

endmodule : display_fetch_arbiter

`default_nettype wire

// File: tb/tb_display_fetch_arbiter.sv
// ============================================================================
//  Module      : tb_display_fetch_arbiter
//  Description : Directed self-checking bench for display_fetch_arbiter
//                (DISP_UNDERFLOW_CNT_EN also checks underflow_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_data;
   logic        eof;
   logic [15:0] pixel_row;
   logic        underflow;
   logic [15:0] vram_addr;
   logic        vram_we;
   logic [15:0] vram_wdata;
   logic [15:0] vram_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;
`ifdef DISP_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] vram [0:65535];

   always #5 clk = ~clk;

   // Two lines of 50 words: the frame ends at word 100.
   display_fetch_arbiter #(
      .ADDR_W     (16),
      .H_WORDS    (50),
      .V_LINES    (2),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK_VGA      (clk),
      .reset        (rst),
      .newData      (new_data),
      .end_of_frame (eof),
      .pixel_row    (pixel_row),
      .underflow    (underflow),
      .vram_addr    (vram_addr),
      .vram_we      (vram_we),
      .vram_wdata   (vram_wdata),
      .vram_rdata   (vram_rdata),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_gnt      (cpu_gnt),
      .cpu_rvalid   (cpu_rvalid),
      .cpu_rdata    (cpu_rdata)
`ifdef DISP_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt (underflow_cnt)
`endif
   );

   always @(posedge clk) begin
      if (vram_we) vram[vram_addr] <= vram_wdata;
      vram_rdata <= vram[vram_addr];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) vram[i] = i[15:0];
      rst       = 1'b1;
      new_data  = 1'b0;
      eof       = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      repeat (2) tick();
      #1;
      check("rst_pixel_row", pixel_row, 0);
      check("rst_underflow", underflow, 0);
      check("rst_vram_addr", vram_addr, 0);
      check("rst_vram_we", vram_we, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
`ifdef DISP_UNDERFLOW_CNT_EN
      check("rst_underflow_cnt", underflow_cnt, 0);
`endif

      // Prefill issues 0..3 back to back.
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("prefill_addr", vram_addr, i);
         check("prefill_we", vram_we, 0);
         tick();
      end
      repeat (3) tick();
      check("prefill_pixel_row", pixel_row, 0);
      check("prefill_idle_addr", vram_addr, 0);

      // Steady-state scan-out at one pop per 16 cycles.
      for (int w = 0; w <= 50; w++) begin
         check("scan_pixel_row", pixel_row, w);
         if (w < 50) begin
            new_data = 1'b1;
            tick();
            new_data = 1'b0;
            repeat (15) tick();
         end
      end
      check("scan_underflow", underflow, 0);

      // CPU write then read while the FIFO is full.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hBEEF;
      #1;
      check("wr_gnt", cpu_gnt, 1);
      check("wr_vram_we", vram_we, 1);
      check("wr_vram_addr", vram_addr, 16'h1234);
      check("wr_vram_wdata", vram_wdata, 16'hBEEF);
      tick();
      cpu_we = 1'b0;
      #1;
      check("rd_gnt", cpu_gnt, 1);
      check("rd_vram_we", vram_we, 0);
      check("rd_rvalid_early", cpu_rvalid, 0);
      tick();
      cpu_req = 1'b0;
      #1;
      check("rd_rvalid", cpu_rvalid, 1);
      check("rd_rdata", cpu_rdata, 16'hBEEF);

      // CPU request arrives while a display refill is due.
      new_data = 1'b1;
      tick();
      new_data = 1'b0;
      cpu_req = 1'b1;
      #1;
      check("drain_gnt_blocked", cpu_gnt, 0);
      check("drain_disp_addr", vram_addr, 54);
      check("drain_pixel_row", pixel_row, 51);
      tick();
      check("drain_gnt", cpu_gnt, 1);
      check("drain_cpu_addr", vram_addr, 16'h1234);
      tick();
      cpu_req = 1'b0;
      #1;
      check("drain_rvalid", cpu_rvalid, 1);
      check("drain_rdata", cpu_rdata, 16'hBEEF);

      // end_of_frame with a display read in flight, plus a CPU read in that cycle.
      new_data = 1'b1;
      tick();
      new_data = 1'b0;
      #1;
      check("eof_inflight_addr", vram_addr, 55);
      tick();
      eof = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      #1;
      check("eof_cpu_gnt", cpu_gnt, 1);
      check("eof_cpu_addr", vram_addr, 16'h1234);
      tick();
      eof = 1'b0; cpu_req = 1'b0;
      #1;
      check("eof_rvalid", cpu_rvalid, 1);
      check("eof_rdata", cpu_rdata, 16'hBEEF);
      check("eof_flushed_row", pixel_row, 0);
      check("eof_refetch_addr0", vram_addr, 0);
      tick();
      check("eof_refetch_addr1", vram_addr, 1);
      repeat (6) tick();
      check("eof_head_word0", pixel_row, 0);
      new_data = 1'b1;
      tick();
      new_data = 1'b0;
      #1;
      check("eof_head_word1", pixel_row, 1);

      // Drain through the end of the frame, then starve the FIFO.
      for (int e = 1; e < 96; e++) begin
         check("frame_pixel_row", pixel_row, e);
         new_data = 1'b1;
         tick();
         new_data = 1'b0;
         repeat (3) tick();
      end
      repeat (4) tick();
      check("done_head", pixel_row, 96);
      check("done_no_fetch", vram_addr, 0);
      for (int k = 0; k < 5; k++) begin
         check("starve_underflow_pre", underflow, 0);
         check("starve_pixel_row", pixel_row, (k < 4) ? 96 + k : 0);
         new_data = 1'b1;
         tick();
         new_data = 1'b0;
         tick();
      end
      check("starve_underflow", underflow, 1);
      check("starve_pixel_row_empty", pixel_row, 0);
      check("starve_no_refill", vram_addr, 0);
`ifdef DISP_UNDERFLOW_CNT_EN
      check("starve_underflow_cnt", underflow_cnt, 1);
`endif
      new_data = 1'b1;
      tick();
      new_data = 1'b0;
      #1;
      check("underflow_sticky", underflow, 1);
`ifdef DISP_UNDERFLOW_CNT_EN
      check("underflow_cnt_two", underflow_cnt, 2);
`endif

      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rerst_underflow", underflow, 0);
`ifdef DISP_UNDERFLOW_CNT_EN
      check("rerst_underflow_cnt", underflow_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_display_fetch_arbiter

`default_nettype wire
